// File: rtl/mm_top.sv
// -----------------------------------------------------------------------------
// mm_top -- Burrows-Wheeler transform engine.
//
// Builds the suffix array of an N-byte string by prefix doubling. Each
// doubling pass is an odd-even transposition sort of sa[] followed by a dense
// re-ranking walk. The BWT string is then derived from the suffix array. The
// last byte of the string must be a unique minimum sentinel ('$').
//
// Parameters:
//   N       string length in bytes (2..255)
//   RANK_W  width of index registers, >= $clog2(N)+1
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; aborts any job in flight
//   input_string   N bytes; input_string[k] is the character at position k
//   start_sort     one-cycle start pulse, accepted only in IDLE
//   suffixes_out   suffixes_out[k] = start index of the k-th smallest suffix
//   output_string  output_string[k] = input_string[(suffixes_out[k]+N-1) % N]
//   done           high from completion until the next accepted start_sort
//
// Configuration macro:
//   MM_TOP_EARLY_EXIT_EN  when defined, leave the doubling loop as soon as
//                         all ranks are distinct. When undefined, all
//                         ceil(log2 N)+1 passes run and latency is fixed.
//                         Results are identical either way.
// -----------------------------------------------------------------------------
module mm_top #(
  parameter int N      = 8,
  parameter int RANK_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_string  [N],
  input  logic       start_sort,
  output logic [7:0] suffixes_out  [N],
  output logic [7:0] output_string [N],
  output logic       done
);

  // Ranks start out as raw byte values, so they need at least 8 bits.
  localparam int RK = (RANK_W > 8) ? RANK_W : 8;
  // k reaches 2*k_prev < 2N, one bit more than an index.
  localparam int KW = RANK_W + 1;

  localparam logic [RANK_W-1:0] LAST_IDX  = RANK_W'(N - 1);
  localparam logic [RK-1:0]     LAST_RANK = RK'(N - 1);
  localparam logic [KW-1:0]     N_K       = KW'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_RERANK,
    S_BWT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [7:0]        str_q      [N];
  logic [RANK_W-1:0] sa_q       [N];
  logic [RK-1:0]     rank_q     [N];
  logic [RK-1:0]     new_rank_q [N];
  logic [7:0]        stage_q    [N];
  logic [KW-1:0]     k_q;
  logic [RANK_W-1:0] cnt_q;
  logic [RK-1:0]     cur_rank_q;

  // Per-slot sort keys: key of suffix sa_q[j] is {rank[sa], rank[sa+k]+1 or 0}.
  logic [RK-1:0]     key_hi   [N];
  logic [RK-1:0]     key_lo   [N];
  logic [KW-1:0]     pos_w    [N];
  logic [2*RK-1:0]   key_w    [N];
  logic [RANK_W-1:0] sa_cnt;
  logic [RANK_W-1:0] prev_pos;
  logic [2*RK-1:0]   key_cnt;
  logic [2*RK-1:0]   key_prev;
  logic [RK-1:0]     cur_rank_d;
  logic [KW-1:0]     k_d;
  logic [7:0]        bwt_char;
  logic              last_cnt;
  logic              go_bwt;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    sa_cnt   = '0;
    key_cnt  = '0;
    key_prev = '0;
    bwt_char = '0;
    for (int j = 0; j < N; j++) begin
      key_hi[j] = '0;
      key_lo[j] = '0;
      // i+k is widened and only matches a real position when it is < N, so
      // the index never wraps through 2^RANK_W.
      pos_w[j]  = {1'b0, sa_q[j]} + k_q;
      for (int i = 0; i < N; i++) begin
        if (sa_q[j] == RANK_W'(i)) key_hi[j] = rank_q[i];
        if ((k_q != '0) && (pos_w[j] == KW'(i))) key_lo[j] = rank_q[i] + 1'b1;
      end
      key_w[j] = {key_hi[j], key_lo[j]};
    end

    for (int j = 0; j < N; j++) begin
      if (cnt_q == RANK_W'(j)) begin
        sa_cnt  = sa_q[j];
        key_cnt = key_w[j];
      end
      if (cnt_q == RANK_W'(j + 1)) key_prev = key_w[j];
    end

    if (cnt_q == '0) cur_rank_d = '0;
    else             cur_rank_d = cur_rank_q + RK'(key_cnt != key_prev);

    // Character preceding suffix sa_cnt, with position 0 wrapping to N-1.
    prev_pos = (sa_cnt == '0) ? LAST_IDX : sa_cnt - 1'b1;
    for (int i = 0; i < N; i++) begin
      if (prev_pos == RANK_W'(i)) bwt_char = str_q[i];
    end

    k_d      = (k_q == '0) ? KW'(1) : (k_q << 1);
    last_cnt = (cnt_q == LAST_IDX);
`ifdef MM_TOP_EARLY_EXIT_EN
    go_bwt   = (cur_rank_d == LAST_RANK) || (k_d >= N_K);
`else
    go_bwt   = (k_d >= N_K);
`endif
  end

  // NOTE: all state, including the arrays, uses non-blocking assignments so
  // every read in this block sees the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the arrays are reset too, so an aborted job can never leak
      // partial data into the published outputs.
      state_q    <= S_IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      cur_rank_q <= '0;
      done       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        str_q[i]         <= '0;
        sa_q[i]          <= '0;
        rank_q[i]        <= '0;
        new_rank_q[i]    <= '0;
        stage_q[i]       <= '0;
        suffixes_out[i]  <= '0;
        output_string[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_sort) begin
            str_q   <= input_string;
            done    <= 1'b0;
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          for (int i = 0; i < N; i++) begin
            sa_q[i]   <= RANK_W'(i);
            rank_q[i] <= RK'(str_q[i]);
          end
          k_q     <= '0;
          cnt_q   <= '0;
          state_q <= S_SORT;
        end

        S_SORT: begin
          // Even cycles pair (0,1),(2,3)..; odd cycles pair (1,2),(3,4)..
          // Pairs never overlap, and equal keys stay put to keep the sort stable.
          for (int j = 0; j < N - 1; j++) begin
            if ((j[0] == cnt_q[0]) && (key_w[j] > key_w[j+1])) begin
              sa_q[j]   <= sa_q[j+1];
              sa_q[j+1] <= sa_q[j];
            end
          end
          cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
          if (last_cnt) state_q <= S_RERANK;
        end

        S_RERANK: begin
          // Old ranks stay live for key generation until the walk finishes.
          for (int i = 0; i < N; i++) begin
            if (sa_cnt == RANK_W'(i)) new_rank_q[i] <= cur_rank_d;
          end
          cur_rank_q <= cur_rank_d;
          cnt_q      <= last_cnt ? '0 : cnt_q + 1'b1;
          if (last_cnt) begin
            for (int i = 0; i < N; i++) begin
              rank_q[i] <= (sa_cnt == RANK_W'(i)) ? cur_rank_d : new_rank_q[i];
            end
            k_q     <= k_d;
            state_q <= go_bwt ? S_BWT : S_SORT;
          end
        end

        S_BWT: begin
          for (int i = 0; i < N; i++) begin
            if (cnt_q == RANK_W'(i)) stage_q[i] <= bwt_char;
          end
          cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
          if (last_cnt) state_q <= S_DONE;
        end

        S_DONE: begin
          for (int i = 0; i < N; i++) begin
            suffixes_out[i]  <= 8'(sa_q[i]);
            output_string[i] <= stage_q[i];
          end
          done    <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_top.sv
// -----------------------------------------------------------------------------
// tb_mm_top -- directed self-checking bench for mm_top (N=8, RANK_W=4).
// Strings and results are packed 64-bit values, position/slot 0 in the top
// byte, so string literals read naturally.
// -----------------------------------------------------------------------------
module tb_mm_top;

  localparam int N       = 8;
  localparam int MAX_LAT = 79;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_sort;
  logic [7:0] input_string  [N];
  logic [7:0] suffixes_out  [N];
  logic [7:0] output_string [N];
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  mm_top #(.N(N), .RANK_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_string (input_string),
    .start_sort   (start_sort),
    .suffixes_out (suffixes_out),
    .output_string(output_string),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_sa();
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r = {r[55:0], suffixes_out[i]};
    return r;
  endfunction

  function automatic logic [63:0] pack_bwt();
    logic [63:0] r = '0;
    for (int i = 0; i < N; i++) r = {r[55:0], output_string[i]};
    return r;
  endfunction

  task automatic load_str(input logic [63:0] s);
    for (int k = 0; k < N; k++) input_string[k] = s[63-8*k -: 8];
  endtask

  // Start is raised after a falling edge and dropped after the next one, so
  // exactly one rising edge samples it.
  task automatic pulse_start();
    @(negedge clk) start_sort = 1'b1;
    @(negedge clk) start_sort = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [63:0] s,
                         input logic [63:0] exp_sa, input logic [63:0] exp_bwt);
    int lat;
    load_str(s);
    pulse_start();
    check({tag, "_done_clr"}, 64'(done), 64'd0);
    wait_done(tag, lat);
    check({tag, "_lat_ok"}, 64'(lat <= MAX_LAT), 64'd1);
    check({tag, "_sa"}, pack_sa(), exp_sa);
    check({tag, "_bwt"}, pack_bwt(), exp_bwt);
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    start_sort = 1'b0;
    load_str(64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_done", 64'(done), 64'd0);
    check("rst_sa",   pack_sa(),  64'd0);
    check("rst_bwt",  pack_bwt(), 64'd0);

    // $ < iss$ < ississ$ < mississ$ < s$ < siss$ < ss$ < ssiss$
    run_job("miss", "mississ$", 64'h07_04_01_00_06_03_05_02, "ssm$ssii");

    // Outputs and done hold while idle.
    repeat (5) @(negedge clk);
    check("hold_done", 64'(done), 64'd1);
    check("hold_sa",   pack_sa(), 64'h07_04_01_00_06_03_05_02);

    // '$' sorts below every letter: $ < a$ < abanana$ < ana$ < anana$
    // < banana$ < na$ < nana$
    run_job("banana", "abanana$", 64'h07_06_00_04_02_01_05_03, "an$nbaaa");

    run_job("sorted", "abcdefg$", 64'h07_00_01_02_03_04_05_06, "g$abcdef");

    // Busy: a second start and a changed input must not disturb the job.
    load_str("mississ$");
    pulse_start();
    repeat (3) @(negedge clk);
    load_str("abcdefg$");
    start_sort = 1'b1;
    @(negedge clk) start_sort = 1'b0;
    repeat (20) @(negedge clk);
    load_str("zyxwvut$");
    start_sort = 1'b1;
    @(negedge clk) start_sort = 1'b0;
    wait_done("busy", lat);
    check("busy_sa",  pack_sa(),  64'h07_04_01_00_06_03_05_02);
    check("busy_bwt", pack_bwt(), "ssm$ssii");

    // Reset in the middle of SORT aborts the job and clears the outputs.
    load_str("abanana$");
    pulse_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("abort_done", 64'(done), 64'd0);
    check("abort_sa",   pack_sa(),  64'd0);
    check("abort_bwt",  pack_bwt(), 64'd0);
    repeat (80) @(negedge clk);
    check("abort_idle_done", 64'(done), 64'd0);
    check("abort_idle_sa",   pack_sa(),  64'd0);

    run_job("after_rst", "abcdefg$", 64'h07_00_01_02_03_04_05_06, "g$abcdef");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
